// File: rtl/multi_target_select_pkg.sv
// rtl/multi_target_select_pkg.sv - shared types and constants for multi-target colour selection
package multi_target_select_pkg;

   typedef enum logic [1:0] {
      AIM     = 2'd0,
      PREVIEW = 2'd1,
      LOCK    = 2'd2,
      MOVE    = 2'd3
   } state_t;

   typedef logic [11:0] pixel_t;

   localparam logic [10:0] DEFAULT_CURSOR_X = 11'd15;
   localparam logic [9:0]  DEFAULT_CURSOR_Y = 10'd15;
   localparam pixel_t      SAMPLE_RESET     = 12'hff0;

   localparam int FULL_W = 640;
   localparam int FULL_H = 480;
   localparam int HALF_W = 320;
   localparam int HALF_H = 240;

endpackage

// File: rtl/multi_target_select_window.sv
// rtl/multi_target_select_window.sv - square window averager under the cursor
import multi_target_select_pkg::*;

module window_averager #(
   parameter int SAMPLE_LOG2 = 2
) (
   input  logic        clk_65mhz,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [10:0] cursor_x,
   input  logic [9:0]  cursor_y,
   input  pixel_t      cam,
   output pixel_t      sample_pixel
);

   localparam int SW   = 4 + 2 * SAMPLE_LOG2;
   localparam int SIDE = 1 << SAMPLE_LOG2;
   localparam int HALF = SIDE / 2;
   // Window is [c-HALF, c-HALF+SIDE); written additively so the lower edge clamps at 0.
   localparam logic [11:0] HALF_V = 12'(HALF);
   localparam logic [11:0] TAIL_V = 12'(SIDE - HALF);

   logic          in_x, in_y;
   logic [SW-1:0] sum_r, sum_g, sum_b;

   assign in_x = (({1'b0, hcount} + HALF_V) >= {1'b0, cursor_x}) &&
                 ({1'b0, hcount} < ({1'b0, cursor_x} + TAIL_V));
   assign in_y = (({2'b0, vcount} + HALF_V) >= {2'b0, cursor_y}) &&
                 ({2'b0, vcount} < ({2'b0, cursor_y} + TAIL_V));

   // Accumulate window pixels; at frame start publish the averages and restart.
   always_ff @(posedge clk_65mhz or negedge reset_n) begin
      if (!reset_n) begin
         sum_r        <= '0;
         sum_g        <= '0;
         sum_b        <= '0;
         sample_pixel <= SAMPLE_RESET;
      end else if (frame_start) begin
         sample_pixel <= {sum_r[SW-1 -: 4], sum_g[SW-1 -: 4], sum_b[SW-1 -: 4]};
         sum_r        <= '0;
         sum_g        <= '0;
         sum_b        <= '0;
      end else if (in_x && in_y) begin
         sum_r <= sum_r + SW'(cam[11:8]);
         sum_g <= sum_g + SW'(cam[7:4]);
         sum_b <= sum_b + SW'(cam[3:0]);
      end
   end

endmodule

// File: rtl/multi_target_select.sv
// rtl/multi_target_select.sv - cursor, colour sampling and N-target capture FSM
import multi_target_select_pkg::*;

module multi_target_select #(
   parameter int NUM_TARGETS = 2,
   parameter int SAMPLE_LOG2 = 2,
   parameter int CURSOR_STEP = 3,
   localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
   input  logic                     clk_65mhz,
   input  logic                     reset_n,
   input  logic [10:0]              hcount,
   input  logic [9:0]               vcount,
   input  logic                     vsync,
   input  logic                     up,
   input  logic                     down,
   input  logic                     left,
   input  logic                     right,
   input  logic                     confirm,
   input  logic                     activate,
   input  logic                     full_res,
   input  logic [11:0]              cam,
   input  logic [6:0]               cur_rad,
   output logic [10:0]              cursor_x,
   output logic [9:0]               cursor_y,
   output logic [11:0]              sample_pixel,
   output logic [IDX_W-1:0]         target_idx,
   output logic [12*NUM_TARGETS-1:0] goal_pixel,
   output logic [7*NUM_TARGETS-1:0] goal_rad,
   output logic [NUM_TARGETS-1:0]   goal_valid,
   output logic [1:0]               state,
   output logic                     track,
   output logic                     move
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TARGETS - 1);
   localparam logic [11:0]      STEP     = 12'(CURSOR_STEP);

   state_t      state_q;
   logic        vsync_d, confirm_d, activate_d;
   logic        confirm_p, activate_p, any_dir;
   logic        frame_start;
   logic [11:0] x_max, y_max, nx, ny;

   assign frame_start = vsync & ~vsync_d;
   assign state       = state_q;

   // Edge detectors; pulses and the direction level are registered so they line up in the FSM.
   always_ff @(posedge clk_65mhz or negedge reset_n) begin
      if (!reset_n) begin
         vsync_d    <= 1'b0;
         confirm_d  <= 1'b0;
         activate_d <= 1'b0;
         confirm_p  <= 1'b0;
         activate_p <= 1'b0;
         any_dir    <= 1'b0;
      end else begin
         vsync_d    <= vsync;
         confirm_d  <= confirm;
         activate_d <= activate;
         confirm_p  <= confirm & ~confirm_d;
         activate_p <= activate & ~activate_d;
         any_dir    <= up | down | left | right;
      end
   end

   // Next cursor position: step per held direction, then clamp into the active resolution.
   always_comb begin
      x_max = full_res ? 12'(FULL_W - 1) : 12'(HALF_W - 1);
      y_max = full_res ? 12'(FULL_H - 1) : 12'(HALF_H - 1);
      nx    = {1'b0, cursor_x};
      ny    = {2'b0, cursor_y};
      if (left && !right)
         nx = (nx < STEP) ? 12'd0 : nx - STEP;
      else if (right && !left)
         nx = nx + STEP;
      if (up && !down)
         ny = (ny < STEP) ? 12'd0 : ny - STEP;
      else if (down && !up)
         ny = ny + STEP;
      if (nx > x_max)
         nx = x_max;
      if (ny > y_max)
         ny = y_max;
   end

   // Cursor moves once per frame, only while aiming or previewing.
   always_ff @(posedge clk_65mhz or negedge reset_n) begin
      if (!reset_n) begin
         cursor_x <= DEFAULT_CURSOR_X;
         cursor_y <= DEFAULT_CURSOR_Y;
      end else if (frame_start && (state_q == AIM || state_q == PREVIEW)) begin
         cursor_x <= nx[10:0];
         cursor_y <= ny[9:0];
      end
   end

   window_averager #(
      .SAMPLE_LOG2 (SAMPLE_LOG2)
   ) u_window (
      .clk_65mhz    (clk_65mhz),
      .reset_n      (reset_n),
      .frame_start  (frame_start),
      .hcount       (hcount),
      .vcount       (vcount),
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .cam          (cam),
      .sample_pixel (sample_pixel)
   );

   // Selection FSM: aim/preview per target, lock when all captured, move until re-activated.
   always_ff @(posedge clk_65mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= AIM;
         target_idx <= '0;
         goal_pixel <= '0;
         goal_rad   <= '0;
         goal_valid <= '0;
         track      <= 1'b0;
         move       <= 1'b0;
      end else if (activate_p) begin
         state_q    <= AIM;
         target_idx <= '0;
         goal_valid <= '0;
         track      <= 1'b0;
         move       <= 1'b0;
      end else begin
         case (state_q)
            AIM: begin
               if (confirm_p) begin
                  state_q                        <= PREVIEW;
                  goal_pixel[target_idx*12 +: 12] <= sample_pixel;
                  track                          <= 1'b1;
               end
            end
            PREVIEW: begin
               if (any_dir) begin
                  state_q <= AIM;
                  track   <= 1'b0;
               end else if (confirm_p) begin
                  goal_rad[target_idx*7 +: 7] <= cur_rad;
                  goal_valid[target_idx]      <= 1'b1;
                  if (target_idx == LAST_IDX) begin
                     state_q <= LOCK;
                  end else begin
                     target_idx <= target_idx + 1'b1;
                     state_q    <= AIM;
                     track      <= 1'b0;
                  end
               end
            end
            LOCK: begin
               if (!activate_d) begin
                  state_q <= MOVE;
                  move    <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
